// File: rtl/dct2_1d_stream_if.sv
// Sample-in / coefficient-out stream bundle for dct2_1d_stream.
// slave = engine side, master = producer/consumer side.
interface dct2_1d_stream_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
);
    logic [1:0]              size;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_last;

    modport slave (
        input  size, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output size, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/dct2_1d_stream.sv
// Time-multiplexed 1-D VVC DCT-II (N=4/8/16/32), one MAC per cycle.
// Latency: N load cycles, then y[0] valid N+1 cycles after the last sample; N cycles per coefficient.
// Backpressure: out_ready low stalls only at coefficient boundaries (HOLD); in_ready only in LOAD.
module dct2_1d_stream #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int SHIFT = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    dct2_1d_stream_if.slave s
);
    localparam int ACC_W  = IN_W + 13;
    localparam int PROD_W = IN_W + 8;
    localparam int RND_W  = ACC_W + 1;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic signed [RND_W-1:0] RND_BIAS = RND_W'(1) << (SHIFT - 1);
    localparam logic signed [RND_W-1:0] SAT_MAX  = RND_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] SAT_MIN  = ~SAT_MAX;

    logic [1:0]              state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [4:0]              k_q, k_d;
    logic [1:0]              n_reg_q, n_reg_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [31:0][IN_W-1:0]   smp_q, smp_d;
    logic                    out_vld_q, out_vld_d;
    logic signed [OUT_W-1:0] out_dat_q, out_dat_d;
    logic                    out_last_q, out_last_d;

    logic                     in_acc;
    logic                     out_pop;
    logic                     out_free;
    logic                     out_wr;
    logic [1:0]               cur_sz;
    logic [4:0]               nm1;
    logic signed [7:0]        coef;
    logic signed [IN_W-1:0]   smp;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  fin_sum;
    logic signed [RND_W-1:0]  rnd;
    logic signed [RND_W-1:0]  shr;
    logic signed [OUT_W-1:0]  sat;

    // |T32| magnitudes indexed by angle j in units of pi/64; j=0 only occurs on the DC row.
    function automatic logic [6:0] cos_mag(input logic [5:0] j);
        case (j)
            6'd0:  cos_mag = 7'd64;
            6'd1:  cos_mag = 7'd90;
            6'd2:  cos_mag = 7'd90;
            6'd3:  cos_mag = 7'd90;
            6'd4:  cos_mag = 7'd89;
            6'd5:  cos_mag = 7'd88;
            6'd6:  cos_mag = 7'd87;
            6'd7:  cos_mag = 7'd85;
            6'd8:  cos_mag = 7'd83;
            6'd9:  cos_mag = 7'd82;
            6'd10: cos_mag = 7'd80;
            6'd11: cos_mag = 7'd78;
            6'd12: cos_mag = 7'd75;
            6'd13: cos_mag = 7'd73;
            6'd14: cos_mag = 7'd70;
            6'd15: cos_mag = 7'd67;
            6'd16: cos_mag = 7'd64;
            6'd17: cos_mag = 7'd61;
            6'd18: cos_mag = 7'd57;
            6'd19: cos_mag = 7'd54;
            6'd20: cos_mag = 7'd50;
            6'd21: cos_mag = 7'd46;
            6'd22: cos_mag = 7'd43;
            6'd23: cos_mag = 7'd38;
            6'd24: cos_mag = 7'd36;
            6'd25: cos_mag = 7'd31;
            6'd26: cos_mag = 7'd25;
            6'd27: cos_mag = 7'd22;
            6'd28: cos_mag = 7'd18;
            6'd29: cos_mag = 7'd13;
            6'd30: cos_mag = 7'd9;
            6'd31: cos_mag = 7'd4;
            default: cos_mag = 7'd0;
        endcase
    endfunction

    // T32[row][col] = cos(pi*row*(2col+1)/64), folded into the first quadrant for the table.
    function automatic logic signed [7:0] t32(input logic [4:0] row, input logic [4:0] col);
        logic [6:0] ang;
        logic [6:0] fold;
        logic [5:0] j;
        logic       neg;
        logic [6:0] mag;
        ang  = 7'(row) * 7'({col, 1'b1});
        fold = ang[6] ? (7'd0 - ang) : ang;
        neg  = (fold > 7'd32);
        j    = neg ? 6'(7'd64 - fold) : fold[5:0];
        mag  = cos_mag(j);
        t32  = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    function automatic logic [4:0] last_idx(input logic [1:0] sz);
        last_idx = 5'((6'd4 << sz) - 6'd1);
    endfunction

    assign in_acc   = s.in_valid && s.in_ready;
    assign out_pop  = out_vld_q && s.out_ready;
    assign out_free = !out_vld_q || s.out_ready;
    assign nm1      = last_idx(n_reg_q);

    assign s.in_ready  = rst_n && (state_q == ST_LOAD);
    assign s.out_valid = out_vld_q;
    assign s.out_data  = out_dat_q;
    assign s.out_last  = out_last_q;

    // Row of T32 for coefficient k of an N-point transform is k*32/N.
    assign coef    = t32(5'(k_q << (2'd3 - n_reg_q)), cnt_q);
    assign smp     = $signed(smp_q[cnt_q]);
    assign prod    = PROD_W'(coef) * PROD_W'(smp);
    assign fin_sum = (state_q == ST_HOLD) ? acc_q : acc_q + ACC_W'(prod);
    assign rnd     = RND_W'(fin_sum) + RND_BIAS;
    assign shr     = rnd >>> SHIFT;

    always_comb begin
        sat = shr[OUT_W-1:0];
        if (shr > SAT_MAX) begin
            sat = SAT_MAX[OUT_W-1:0];
        end else if (shr < SAT_MIN) begin
            sat = SAT_MIN[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        n_reg_d = n_reg_q;
        acc_d   = acc_q;
        smp_d   = smp_q;
        out_wr  = 1'b0;
        cur_sz  = (cnt_q == 5'd0) ? s.size : n_reg_q;
        case (state_q)
            ST_LOAD: begin
                if (in_acc) begin
                    smp_d[cnt_q] = s.in_data;
                    if (cnt_q == 5'd0) begin
                        n_reg_d = s.size;
                    end
                    if (cnt_q == last_idx(cur_sz)) begin
                        cnt_d   = 5'd0;
                        k_d     = 5'd0;
                        acc_d   = '0;
                        state_d = ST_CALC;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_CALC: begin
                if (cnt_q == nm1) begin
                    if (out_free) begin
                        out_wr = 1'b1;
                    end else begin
                        acc_d   = fin_sum;
                        state_d = ST_HOLD;
                    end
                end else begin
                    acc_d = fin_sum;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_HOLD: begin
                if (out_pop) begin
                    out_wr = 1'b1;
                end
            end
            default: state_d = ST_LOAD;
        endcase
        if (out_wr) begin
            cnt_d = 5'd0;
            acc_d = '0;
            if (k_q == nm1) begin
                k_d     = 5'd0;
                state_d = ST_LOAD;
            end else begin
                k_d     = k_q + 5'd1;
                state_d = ST_CALC;
            end
        end
    end

    // Writing takes priority over popping so a same-cycle refill keeps out_valid high.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_last_d = out_last_q;
        if (out_wr) begin
            out_vld_d  = 1'b1;
            out_dat_d  = sat;
            out_last_d = (k_q == nm1);
        end else if (out_pop) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            cnt_q      <= '0;
            k_q        <= '0;
            n_reg_q    <= '0;
            acc_q      <= '0;
            smp_q      <= '0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            n_reg_q    <= n_reg_d;
            acc_q      <= acc_d;
            smp_q      <= smp_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_last_q <= out_last_d;
        end
    end
endmodule

// File: tb/tb_dct2_1d_stream.sv
// Scoreboard bench for dct2_1d_stream: instance A (SHIFT=11) and instance B (SHIFT=6).
module tb_dct2_1d_stream;
    typedef struct packed {
        logic signed [15:0] d;
        logic               l;
    } exp_t;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dct2_1d_stream_if #(.IN_W(16), .OUT_W(16)) ifa ();
    dct2_1d_stream_if #(.IN_W(16), .OUT_W(16)) ifb ();

    dct2_1d_stream #(.IN_W(16), .OUT_W(16), .SHIFT(11)) u_a (.clk(clk), .rst_n(rst_n), .s(ifa.slave));
    dct2_1d_stream #(.IN_W(16), .OUT_W(16), .SHIFT(6))  u_b (.clk(clk), .rst_n(rst_n), .s(ifb.slave));

    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   outs_a = 0;
    int   last_cyc_a = -1;
    int   blk[32];
    int   acc_first, acc_last;
    int   imp_exp[8] = '{31, 43, 41, 37, 31, 24, 18, 9};
    int   mag_tab[33] = '{64, 90, 90, 90, 89, 88, 87, 85, 83, 82, 80, 78, 75, 73, 70, 67, 64,
                          61, 57, 54, 50, 46, 43, 38, 36, 31, 25, 22, 18, 13, 9, 4, 0};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Matrix entry recovered from the real cosine: sign from cos, magnitude from the VVC table.
    function automatic int coef(input int row, input int col);
        real r, ar;
        int  j;
        if (row == 0) return 64;
        r  = $cos(PI * row * (2 * col + 1) / 64.0);
        ar = (r < 0.0) ? -r : r;
        j  = $rtoi($acos(ar) * 64.0 / PI + 0.5);
        return (r < 0.0) ? -mag_tab[j] : mag_tab[j];
    endfunction

    function automatic int model_y(input int row, input int n, input int sh);
        longint sum = 0;
        longint r;
        for (int i = 0; i < n; i++) sum += longint'(coef(row, i)) * longint'(blk[i]);
        r = (sum + (longint'(1) <<< (sh - 1))) >>> sh;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic push_exp(input bit w, input int d, input bit l);
        exp_t e;
        e.d = 16'(d);
        e.l = l;
        if (w) qb.push_back(e);
        else   qa.push_back(e);
    endtask

    task automatic push_model(input bit w, input logic [1:0] sz, input int sh);
        int n = 4 << sz;
        for (int k = 0; k < n; k++) push_exp(w, model_y(k * (32 / n), n, sh), k == n - 1);
    endtask

    task automatic drive(input bit w, input bit v, input logic [1:0] sz, input int d);
        if (w) begin
            ifb.in_valid = v; ifb.size = sz; ifb.in_data = 16'(d);
        end else begin
            ifa.in_valid = v; ifa.size = sz; ifa.in_data = 16'(d);
        end
    endtask

    function automatic bit rdy(input bit w);
        return w ? ifb.in_ready : ifa.in_ready;
    endfunction

    // Caller is aligned at posedge+1; size changes to sz_rest after the first sample.
    task automatic send_block(input bit w, input logic [1:0] sz, input logic [1:0] sz_rest);
        int n = 4 << sz;
        for (int i = 0; i < n; i++) begin
            int waited = 0;
            drive(w, 1'b1, (i == 0) ? sz : sz_rest, blk[i]);
            @(negedge clk);
            while (!rdy(w) && waited < 3000) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 3000) chk("in_ready_timeout", waited, 0);
            if (i == 0) acc_first = cyc;
            acc_last = cyc;
            @(posedge clk); #1;
        end
        drive(w, 1'b0, sz, 0);
    endtask

    task automatic drain(input bit w, input string name);
        int t = 0;
        while ((w ? qb.size() : qa.size()) != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk(name, w ? qb.size() : qa.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && ifa.out_valid && ifa.out_ready) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_out: got %0d expected none", ifa.out_data);
            end else begin
                ea = qa.pop_front();
                chk("a_data", int'(ifa.out_data), int'($signed(ea.d)));
                chk("a_last", int'(ifa.out_last), int'(ea.l));
            end
            outs_a++;
            if (ifa.out_last) last_cyc_a = cyc;
        end
    end

    always @(negedge clk) begin
        if (rst_n && ifb.out_valid && ifb.out_ready) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_out: got %0d expected none", ifb.out_data);
            end else begin
                eb = qb.pop_front();
                chk("b_data", int'(ifb.out_data), int'($signed(eb.d)));
                chk("b_last", int'(ifb.out_last), int'(eb.l));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int base;
        logic signed [15:0] bp_y0;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 0);
        drive(1'b1, 1'b0, 2'b00, 0);
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", int'(ifa.in_ready), 0);
        chk("rst_out_valid", int'(ifa.out_valid), 0);
        chk("rst_out_data", int'(ifa.out_data), 0);
        chk("rst_out_last", int'(ifa.out_last), 0);
        chk("rst_b_in_ready", int'(ifb.in_ready), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", int'(ifa.in_ready), 1);

        // DC, N=4
        for (int i = 0; i < 4; i++) blk[i] = 100;
        push_exp(1'b0, 13, 1'b0); push_exp(1'b0, 0, 1'b0);
        push_exp(1'b0, 0, 1'b0);  push_exp(1'b0, 0, 1'b1);
        send_block(1'b0, 2'b00, 2'b00);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ifa.out_valid && t < 100);
        chk("dc_out_valid", int'(ifa.out_valid), 1);
        chk("dc_latency", cyc - acc_last, 5);
        drain(1'b0, "dc_drain");

        // Impulse, N=8, size toggled mid-block
        for (int i = 0; i < 32; i++) blk[i] = 0;
        blk[0] = 1000;
        for (int k = 0; k < 8; k++) push_exp(1'b0, imp_exp[k], k == 7);
        send_block(1'b0, 2'b01, 2'b11);
        drain(1'b0, "imp_drain");

        // Saturation on the SHIFT=6 instance
        for (int i = 0; i < 32; i++) blk[i] = 32767;
        push_exp(1'b1, 32767, 1'b0);
        for (int k = 1; k < 32; k++) push_exp(1'b1, 0, k == 31);
        send_block(1'b1, 2'b11, 2'b11);
        drain(1'b1, "sat_pos_drain");
        for (int i = 0; i < 32; i++) blk[i] = -32768;
        push_exp(1'b1, -32768, 1'b0);
        for (int k = 1; k < 32; k++) push_exp(1'b1, 0, k == 31);
        send_block(1'b1, 2'b11, 2'b11);
        drain(1'b1, "sat_neg_drain");

        // Back-pressure, N=16
        for (int i = 0; i < 16; i++) blk[i] = ((i * 97) % 61 - 30) * 300;
        push_model(1'b0, 2'b10, 11);
        bp_y0 = qa[0].d;
        ifa.out_ready = 1'b0;
        send_block(1'b0, 2'b10, 2'b10);
        t = 0;
        while (!ifa.out_valid && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("bp_out_valid", int'(ifa.out_valid), 1);
        for (int i = 0; i < 50; i++) begin
            chk("bp_hold_data", int'(ifa.out_data), int'(bp_y0));
            chk("bp_hold_valid", int'(ifa.out_valid), 1);
            chk("bp_hold_in_ready", int'(ifa.in_ready), 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        ifa.out_ready = 1'b1;
        drain(1'b0, "bp_drain");

        // Back-to-back N=32 then N=4
        for (int i = 0; i < 32; i++) blk[i] = (i * i * 13) % 2001 - 1000;
        push_model(1'b0, 2'b11, 11);
        send_block(1'b0, 2'b11, 2'b11);
        blk[0] = 500; blk[1] = -1200; blk[2] = 700; blk[3] = 3000;
        push_model(1'b0, 2'b00, 11);
        send_block(1'b0, 2'b00, 2'b00);
        chk("b2b_accept_cycle", acc_first, last_cyc_a);
        drain(1'b0, "b2b_drain");

        // Reset while computing k=5 of a 32-point block
        for (int i = 0; i < 32; i++) blk[i] = ((i * 53) % 97 - 48) * 200;
        push_model(1'b0, 2'b11, 11);
        base = outs_a;
        send_block(1'b0, 2'b11, 2'b11);
        t = 0;
        while (outs_a < base + 5 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("rst_mid_outs", outs_a - base, 5);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", int'(ifa.out_valid), 0);
        chk("rst_mid_in_ready", int'(ifa.in_ready), 0);
        qa.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_in_ready_after", int'(ifa.in_ready), 1);
        for (int i = 0; i < 8; i++) blk[i] = (i - 3) * 1500 + 77;
        push_model(1'b0, 2'b01, 11);
        send_block(1'b0, 2'b01, 2'b01);
        drain(1'b0, "rst_next_drain");

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
